// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter, 16x oversampled.
//
// Purpose
//   On a one-cycle tx_start while idle, serialises din onto tx as one start bit,
//   DBIT data bits (LSB first), an optional even parity bit and a stop period of
//   SB_TICK s_tick pulses. Bit timing comes from the shared 16x baud tick s_tick.
//
// Optional feature
//   `UART_TX_PARITY_EN : when defined, a PARITY state between DATA and STOP
//                        sends the even parity of the data bits.
//
// Parameters
//   DBIT    : data bits per frame (1..8)
//   SB_TICK : stop period in s_tick pulses (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   tx_start     in   one-cycle send request, honoured only in IDLE
//   s_tick       in   one-clk-wide 16x baud tick
//   din[7:0]     in   word to send, captured on the accepting edge
//   tx_done_tick out  one-cycle pulse in the first IDLE cycle after the stop period
//   tx_busy      out  high from the accepting edge until tx_done_tick
//   tx           out  registered serial line, idles high
//   dbg_state_o  out  current FSM state encoding, for debug/checkers
//
// Handshake: tx_start is a single-cycle request with no ready; it is accepted on
// the rising edge where the FSM is IDLE and tx_start=1, and dropped otherwise
// (no queuing). tx_busy is the "not ready" indication for the requester.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx,
  output logic [2:0] dbg_state_o
);

  // Tick counter must reach SB_TICK-1 in STOP and 15 in the other states.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      b_q      <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      b_q      <= b_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // tx_d is decoded from the current state, so the registered line lags the
  // state by one clk: tx falls on the edge after the accepting edge.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    b_d      = b_q;
    tx_d     = 1'b1;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // s_tick is ignored here, so a tick coincident with the start is not counted.
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^din[DBIT-1:0];
`endif
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed testbench for uart_tx.
// Stimulus pushes the expected {parity, data} of every frame that must appear
// into exp_q; an independent line monitor decodes tx at bit centres, waits for
// tx_done_tick and pops/compares. s_tick runs every TDIV clk so whole frames
// fit in a short run; frame timing is checked in units of TDIV.
module tb_uart_tx;

  localparam int CLK_NS = 20;
  localparam int TDIV   = 5;
  localparam int DBIT   = 8;
  localparam int SBT    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB     = DBIT + 1;
`else
  localparam int NB     = DBIT;
`endif
  // Ticks from acceptance to tx_done_tick: start + data (+ parity) + stop.
  localparam int NTICK  = 16 + 16 * NB - 16 * DBIT + 16 * DBIT + SBT;

  logic       clk;
  logic       reset;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;
  logic       tx_done_tick;
  logic       tx_busy;
  logic       tx;
  logic [2:0] dbg_state;

  logic [8:0] exp_q[$];
  int         n_tests;
  int         n_fail;
  int         cyc;
  int         done_cnt;
  int         tick_cnt;

  uart_tx #(.DBIT(DBIT), .SB_TICK(SBT)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .s_tick       (s_tick),
    .din          (din),
    .tx_done_tick (tx_done_tick),
    .tx_busy      (tx_busy),
    .tx           (tx),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset / tick ----------------
  initial begin
    clk = 1'b0;
    forever #(CLK_NS / 2) clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    s_tick   = 1'b0;
    tick_cnt = 0;
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt == TDIV - 1) ? 0 : tick_cnt + 1;
      s_tick   = (tick_cnt == TDIV - 1);
    end
  end

  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (tx_done_tick === 1'b1) done_cnt++;
    end
  end

  initial begin
    #(CLK_NS * 60000);
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller must be positioned just after a negedge.
  task automatic send(input logic [7:0] d, input logic [8:0] e, input bit push, input bit align);
    int g;
    g = 0;
    while (tx_busy !== 1'b0 && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 4000) check("send_wait_idle", 32'(tx_busy), 32'd0);
    if (align) begin
      // Put the request on the same edge as an s_tick pulse.
      g = 0;
      #1;
      while (s_tick !== 1'b1 && g < 100) begin
        @(negedge clk);
        #1;
        g++;
      end
    end
    din      = d;
    tx_start = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    check("busy_on_accept", 32'(tx_busy), 32'd1);
    check("tx_high_on_accept", 32'(tx), 32'd1);
    tx_start = 1'b0;
    din      = ~d;
    @(negedge clk);
    check("start_bit_fall", 32'(tx), 32'd0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((tx_busy !== 1'b0 || exp_q.size() != 0) && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 4000) check("idle_timeout", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_off(input int t0, input int off, inout bit ab);
    while (!ab && (cyc - t0) < off) begin
      @(negedge clk);
      if (reset === 1'b1) ab = 1'b1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int         t0;
    int         el;
    bit         ab;
    logic       start_b;
    logic       stop_b;
    logic       par_b;
    logic [7:0] data;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      t0    = cyc;
      ab    = 1'b0;
      par_b = 1'b0;
      data  = '0;
      wait_off(t0, 7 * TDIV, ab);
      start_b = tx;
      for (int k = 0; k < DBIT; k++) begin
        wait_off(t0, 16 * TDIV * (k + 1) + 7 * TDIV, ab);
        data[k] = tx;
      end
`ifdef UART_TX_PARITY_EN
      wait_off(t0, 16 * TDIV * (DBIT + 1) + 7 * TDIV, ab);
      par_b = tx;
`endif
      wait_off(t0, 16 * TDIV * (NB + 1) + 7 * TDIV, ab);
      stop_b = tx;
      while (!ab && tx_done_tick !== 1'b1 && (cyc - t0) < NTICK * TDIV + 4 * TDIV) begin
        @(negedge clk);
        if (reset === 1'b1) ab = 1'b1;
      end
      if (ab) continue;
      el = cyc - t0;
      check("start_bit_low", 32'(start_b), 32'd0);
      check("stop_bit_high", 32'(stop_b), 32'd1);
      check("done_seen", 32'(tx_done_tick), 32'd1);
      n_tests++;
      if (el < (NTICK - 1) * TDIV || el > NTICK * TDIV - 1) begin
        n_fail++;
        $display("FAIL frame_length: got %0d clk, expected %0d..%0d clk",
                 el, (NTICK - 1) * TDIV, NTICK * TDIV - 1);
      end
      check("busy_low_at_done", 32'(tx_busy), 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got data 0x%0h, expected no frame", data);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", 32'(data), 32'(e[7:0]));
`ifdef UART_TX_PARITY_EN
        check("frame_parity", 32'(par_b), 32'(e[8]));
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : stimulus
    int d0;
    int g;
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    tx_start = 1'b1;
    din      = 8'hAA;

    // Reset held with a pending request.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold_outputs", {29'd0, tx, tx_busy, tx_done_tick}, 32'b100);
      check("reset_hold_state", 32'(dbg_state), 32'd0);
    end
    reset    = 1'b0;
    tx_start = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_after_reset", {30'd0, tx, tx_busy}, 32'b10);
    check("no_done_after_reset", 32'(done_cnt), 32'd0);

    // 0x55, request coincident with an s_tick (that tick must not count).
    send(8'h55, 9'h055, 1'b1, 1'b1);
    wait_idle();

    // Back-to-back: 0x00, then 0xFF requested in the tx_done_tick cycle.
    send(8'h00, 9'h000, 1'b1, 1'b0);
    g = 0;
    while (tx_done_tick !== 1'b1 && g < 4000) begin
      @(negedge clk);
      g++;
    end
    check("b2b_done_seen", 32'(tx_done_tick), 32'd1);
    check("b2b_busy_in_done_cycle", 32'(tx_busy), 32'd0);
    send(8'hFF, 9'h0FF, 1'b1, 1'b0);
    wait_idle();

    // Request while busy is ignored: line keeps 0xA3, single done.
    d0 = done_cnt;
    send(8'hA3, 9'h0A3, 1'b1, 1'b0);
    repeat (16 * TDIV * 3) @(negedge clk);
    din      = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
    repeat (40 * TDIV) @(negedge clk);
    check("busy_ignore_single_done", 32'(done_cnt), 32'(d0 + 1));

    // Reset in the middle of data bit 4 of 0x0F (a low bit).
    d0 = done_cnt;
    send(8'h0F, 9'h000, 1'b0, 1'b0);
    repeat (16 * TDIV * 5 + 8 * TDIV) @(negedge clk);
    check("tx_low_before_abort", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {29'd0, tx, tx_busy, tx_done_tick}, 32'b100);
    @(negedge clk);
    reset = 1'b0;
    repeat (40 * TDIV) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt), 32'(d0));
    check("idle_after_abort", {30'd0, tx, tx_busy}, 32'b10);
    send(8'h81, 9'h081, 1'b1, 1'b0);
    wait_idle();

    // Parity vectors (parity bit only checked when the feature is built).
    send(8'h07, 9'h107, 1'b1, 1'b0);
    wait_idle();
    send(8'h03, 9'h003, 1'b1, 1'b0);
    wait_idle();

    repeat (50) @(negedge clk);
    check("total_done_pulses", 32'(done_cnt), 32'd7);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
